// File: rtl/spi_fifo_master.sv
// Mode-0 SPI master for the SSD1331 OLED behind an Avalon-MM slave: DEPTH-entry word FIFO,
// per-word D/C# tracking, overflow status and a software panel-reset bit.
module spi_fifo_master #(
  parameter int W     = 8,
  parameter int DIV   = 8,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        address,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        sclk,
  output logic        mosi,
  output logic        csn,
  output logic        dcn,
  output logic        resetn
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [TW-1:0] TMAX   = TW'(DIV - 1);
  localparam logic [BW-1:0] BMAX   = BW'(W - 1);
  localparam logic [AW:0]   FULL_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_C  = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [W-1:0]  shreg_q, shreg_d, shifted;
  logic          sclk_q, sclk_d, mosi_q, mosi_d, csn_q, csn_d, dcn_q, dcn_d;
  logic          overflow_q, prst_q;

  logic [W:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [W:0]    head;
  logic          full, empty, push_req, ctrl_wr, push, pop, start, tick;
  logic          unused_ok;

  assign full     = (count_q == FULL_C);
  assign empty    = (count_q == '0);
  assign push_req = write && !address;
  assign ctrl_wr  = write && address;
  // A full FIFO still accepts a word when the FSM pops in the same cycle.
  assign push     = push_req && (!full || pop);
  assign head     = mem_q[rd_ptr_q];
  assign shifted  = shreg_q << 1;
  assign tick     = (timer_q == '0);
  assign unused_ok = ^{read, writedata};

  // NOTE: storage carries no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {~writedata[W], writedata[W-1:0]};
  end

  // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      prst_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + ONE_C;
      else if (!push && pop) count_q <= count_q - ONE_C;
      if (ctrl_wr && writedata[1])          overflow_q <= 1'b0;
      else if (push_req && full && !pop)    overflow_q <= 1'b1;
      if (ctrl_wr) prst_q <= writedata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
      dcn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      dcn_q   <= dcn_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = tick ? timer_q : timer_q - TW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    dcn_d   = dcn_q;
    pop     = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: start = !empty;
      LOAD: if (tick) begin
        state_d = SHIFT;
        sclk_d  = 1'b1;
        timer_d = TMAX;
      end
      SHIFT: if (tick) begin
        timer_d = TMAX;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else if (bit_q == BMAX) begin
          // Last high phase ends the word directly; no trailing low phase.
          state_d = GAP;
          sclk_d  = 1'b0;
          csn_d   = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          sclk_d  = 1'b0;
          shreg_d = shifted;
          mosi_d  = shifted[W-1];
          bit_d   = bit_q + BW'(1);
        end
      end
      GAP: if (tick) begin
        if (!empty) start = 1'b1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      pop     = 1'b1;
      state_d = LOAD;
      timer_d = TMAX;
      bit_d   = '0;
      shreg_d = head[W-1:0];
      dcn_d   = head[W];
      csn_d   = 1'b0;
      sclk_d  = 1'b0;
      mosi_d  = head[W-1];
    end
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign csn      = csn_q;
  assign dcn      = dcn_q;
  assign resetn   = ~(reset | prst_q);
  assign readdata = {16'h0000, 8'(count_q), 3'b000, prst_q, overflow_q, empty, full,
                     (state_q != IDLE) || !empty};

endmodule

// File: tb/tb_spi_fifo_master.sv
// Self-checking bench for spi_fifo_master (W=8, DIV=2, DEPTH=8): a negedge SPI monitor
// deserialises each csn pulse and compares it with the scoreboard queue filled by the tests.
module tb_spi_fifo_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        address = 1'b0;
  logic [31:0] writedata = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        sclk, mosi, csn, dcn, resetn;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [8:0] exp_q [$];
  int         gap_q [$];
  logic       abort = 1'b0;

  spi_fifo_master #(.W(8), .DIV(2), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .address(address), .writedata(writedata),
    .write(write), .read(read), .readdata(readdata),
    .sclk(sclk), .mosi(mosi), .csn(csn), .dcn(dcn), .resetn(resetn)
  );

  always #5 clk = ~clk;

  // SPI monitor: collects one word per csn-low pulse and checks it against the scoreboard.
  logic       prev_csn = 1'b1, prev_sclk = 1'b0, dc0 = 1'b1, dc_ok = 1'b1;
  logic [7:0] rx = '0;
  logic [8:0] e;
  int         nbits = 0, low_cnt = 0, hi_cnt = 0;

  always @(negedge clk) begin
    if (!csn) begin
      if (prev_csn) begin
        gap_q.push_back(hi_cnt);
        rx = '0; nbits = 0; low_cnt = 0; dc0 = dcn; dc_ok = 1'b1;
      end
      low_cnt++;
      if (dcn !== dc0) dc_ok = 1'b0;
      if (sclk && !prev_sclk) begin
        rx = {rx[6:0], mosi};
        nbits++;
      end
    end else if (!prev_csn) begin
      hi_cnt = 1;
      if (abort) begin
        abort = 1'b0;
      end else begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL spi_word: got dc=%0b data=0x%02h but no word expected", dc0, rx);
        end else begin
          e = exp_q.pop_front();
          if ({dc0, rx} !== e || nbits != 8 || low_cnt != 32 || !dc_ok)
            $display("FAIL spi_word: got dc=%0b data=0x%02h bits=%0d csn_low=%0d dc_stable=%0b, want dc=%0b data=0x%02h bits=8 csn_low=32 dc_stable=1",
                     dc0, rx, nbits, low_cnt, dc_ok, e[8], e[7:0]);
          else pass_cnt++;
        end
      end
    end else begin
      hi_cnt++;
    end
    prev_csn  = csn;
    prev_sclk = sclk;
  end

  task automatic bus_write(input logic a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (readdata[0] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (readdata[0] !== 1'b0) $display("FAIL drain_timeout: busy=%0b after %0d cycles, want 0", readdata[0], n);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL words_left: %0d expected words not sent, want 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({csn, sclk, mosi, dcn, resetn} !== 5'b10010)
      $display("FAIL reset_pins: csn/sclk/mosi/dcn/resetn=%05b want 10010", {csn, sclk, mosi, dcn, resetn});
    else pass_cnt++;
    total_cnt++;
    if (readdata !== 32'h4) $display("FAIL reset_status: readdata=0x%08h want 0x00000004", readdata);
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (resetn !== 1'b1) $display("FAIL reset_release: resetn=%0b want 1", resetn);
    else pass_cnt++;
  endtask

  task automatic test_single_word;
    exp_q.push_back({1'b0, 8'hA5});
    bus_write(1'b0, 32'h1A5);
    total_cnt++;
    if (csn !== 1'b1) $display("FAIL csn_t1: csn=%0b in cycle t+1, want 1", csn);
    else pass_cnt++;
    total_cnt++;
    if (readdata[2:0] !== 3'b001 || readdata[15:8] !== 8'd1)
      $display("FAIL status_t1: status[2:0]=%03b count=%0d, want 001 count=1", readdata[2:0], readdata[15:8]);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (csn !== 1'b0 || dcn !== 1'b0 || sclk !== 1'b0 || mosi !== 1'b1)
      $display("FAIL csn_t2: csn=%0b dcn=%0b sclk=%0b mosi=%0b, want 0 0 0 1", csn, dcn, sclk, mosi);
    else pass_cnt++;
    wait_idle(200);
  endtask

  task automatic test_back_to_back;
    gap_q.delete();
    exp_q.push_back({1'b1, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    bus_write(1'b0, 32'h011);
    bus_write(1'b0, 32'h122);
    bus_write(1'b0, 32'h033);
    wait_idle(400);
    total_cnt++;
    if (gap_q.size() != 3 || gap_q[1] != 2 || gap_q[2] != 2)
      $display("FAIL b2b_gaps: pulses=%0d gap1=%0d gap2=%0d, want 3 pulses with gaps 2 2",
               gap_q.size(), gap_q.size() > 1 ? gap_q[1] : -1, gap_q.size() > 2 ? gap_q[2] : -1);
    else pass_cnt++;
  endtask

  task automatic test_overflow;
    // Word 2's push coincides with word 1's pop, so words 1..9 fit and word 10 hits a full FIFO.
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back({i[0], 8'(8'h40 + i)});
      bus_write(1'b0, {23'd0, ~i[0], 8'(8'h40 + i)});
    end
    total_cnt++;
    if (readdata[3] !== 1'b1 || readdata[1] !== 1'b1 || readdata[15:8] !== 8'd8)
      $display("FAIL overflow_set: ovf=%0b full=%0b count=%0d, want 1 1 8", readdata[3], readdata[1], readdata[15:8]);
    else pass_cnt++;
    bus_write(1'b1, 32'h2);
    total_cnt++;
    if (readdata[3] !== 1'b0 || readdata[4] !== 1'b0)
      $display("FAIL overflow_clear: ovf=%0b prst=%0b, want 0 0", readdata[3], readdata[4]);
    else pass_cnt++;
    wait_idle(1000);
  endtask

  task automatic test_panel_reset;
    exp_q.push_back({1'b1, 8'hAA});
    exp_q.push_back({1'b0, 8'h55});
    bus_write(1'b0, 32'h0AA);
    bus_write(1'b0, 32'h155);
    repeat (3) @(posedge clk);
    #1;
    bus_write(1'b1, 32'h1);
    total_cnt++;
    if (resetn !== 1'b0 || readdata[4] !== 1'b1 || csn !== 1'b0 || readdata[0] !== 1'b1)
      $display("FAIL prst_set: resetn=%0b prst=%0b csn=%0b busy=%0b, want 0 1 0 1", resetn, readdata[4], csn, readdata[0]);
    else pass_cnt++;
    repeat (5) @(posedge clk);
    #1;
    bus_write(1'b1, 32'h0);
    total_cnt++;
    if (resetn !== 1'b1 || readdata[4] !== 1'b0)
      $display("FAIL prst_clear: resetn=%0b prst=%0b, want 1 0", resetn, readdata[4]);
    else pass_cnt++;
    wait_idle(400);
  endtask

  task automatic test_reset_mid_word;
    int n = 0;
    int rises = 0;
    logic ps;
    for (int i = 0; i < 4; i++) bus_write(1'b0, 32'h0C0 + i);
    while (sclk !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++;
    if (sclk !== 1'b1) $display("FAIL mid_shift_timeout: sclk=%0b after %0d cycles, want 1", sclk, n);
    else pass_cnt++;
    abort = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    total_cnt++;
    if (csn !== 1'b1 || sclk !== 1'b0 || readdata[15:8] !== 8'd0 || readdata[2] !== 1'b1)
      $display("FAIL mid_reset: csn=%0b sclk=%0b count=%0d empty=%0b, want 1 0 0 1", csn, sclk, readdata[15:8], readdata[2]);
    else pass_cnt++;
    ps = sclk;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sclk && !ps) rises++;
      ps = sclk;
    end
    total_cnt++;
    if (rises != 0 || csn !== 1'b1 || readdata !== 32'h4)
      $display("FAIL after_reset: sclk_rises=%0d csn=%0b readdata=0x%08h, want 0 1 0x00000004", rises, csn, readdata);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_back_to_back;
    test_overflow;
    test_panel_reset;
    test_reset_mid_word;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
